// File: rtl/gpu_pkg.sv
// Shared types and defaults for the frame sequencing logic.
package gpu_pkg;

  // Frame life cycle, from clear/matrix request through drain detection.
  typedef enum logic [2:0] {
    ST_START,
    ST_WAIT_MATRIX,
    ST_WAIT_BUFFER,
    ST_RENDER,
    ST_DRAIN,
    ST_DONE
  } frame_state_t;

  localparam int DEFAULT_FRAME_PERIOD = 2_000_000;
  localparam int DEFAULT_DRAIN_CYCLES = 64;
  localparam int DEFAULT_CLEAR_GUARD  = 4;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Handshake/status bundle between the frame sequencer and the GPU pipeline.
interface frame_sequencer_if;
  logic        buffer_ready_in;
  logic        matrix_valid_in;
  logic        fetch_done_in;
  logic        busy_in;
  logic        pixel_valid_in;
  logic        switch_out;
  logic        clear_out;
  logic        matrix_start_out;
  logic        fetch_rst_out;
  logic        frame_done_out;
  logic [15:0] frame_count_out;
  logic [15:0] pixel_count_out;
  logic [15:0] overrun_count_out;

  // Sequencer side.
  modport master (
    input  buffer_ready_in, matrix_valid_in, fetch_done_in, busy_in, pixel_valid_in,
    output switch_out, clear_out, matrix_start_out, fetch_rst_out, frame_done_out,
    output frame_count_out, pixel_count_out, overrun_count_out
  );

  // Pipeline / environment side.
  modport slave (
    output buffer_ready_in, matrix_valid_in, fetch_done_in, busy_in, pixel_valid_in,
    input  switch_out, clear_out, matrix_start_out, fetch_rst_out, frame_done_out,
    input  frame_count_out, pixel_count_out, overrun_count_out
  );
endinterface

// File: rtl/frame_timer.sv
// Free-running swap-pacing timer: counts 0..FRAME_PERIOD-1 and flags the last count.
module frame_timer
  import gpu_pkg::*;
#(
  parameter int FRAME_PERIOD = DEFAULT_FRAME_PERIOD
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic tick_out
);

  localparam int            TW   = (FRAME_PERIOD > 2) ? $clog2(FRAME_PERIOD) : 1;
  localparam logic [TW-1:0] LAST = TW'(FRAME_PERIOD - 1);

  logic [TW-1:0] timer_q, timer_d;

  // Next count: wrap to zero after the tick cycle.
  // NOTE: combinational blocks assign every output on every path so no latch is inferred.
  always_comb begin
    timer_d = timer_q + TW'(1);
    if (timer_q == LAST) timer_d = '0;
  end

  // Count register with synchronous reset.
  // NOTE: non-blocking assignments make every flop sample pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) timer_q <= '0;
    else        timer_q <= timer_d;
  end

  assign tick_out = (timer_q == LAST);

endmodule

// File: rtl/frame_sequencer.sv
// Sequences one frame: clear + matrix request, guarded buffer wait, render,
// drain detection, then a paced buffer swap with overrun accounting.
module frame_sequencer
  import gpu_pkg::*;
#(
  parameter int FRAME_PERIOD = DEFAULT_FRAME_PERIOD,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
  parameter int CLEAR_GUARD  = DEFAULT_CLEAR_GUARD
) (
  input logic               clk_in,
  input logic               rst_in,
  frame_sequencer_if.master bus
);

  localparam int            IW        = $clog2(DRAIN_CYCLES + 1);
  localparam int            GW        = (CLEAR_GUARD > 0) ? $clog2(CLEAR_GUARD + 1) : 1;
  localparam logic [IW-1:0] IDLE_DONE = IW'(DRAIN_CYCLES);
  localparam logic [GW-1:0] GUARD_MAX = GW'(CLEAR_GUARD);

  logic tick;

  frame_timer #(.FRAME_PERIOD(FRAME_PERIOD)) u_timer (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .tick_out(tick)
  );

  frame_state_t  state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [15:0]   pix_run_q, pix_run_d;
  logic          switch_q, switch_d;
  logic          clear_q, clear_d;
  logic          matrix_start_q, matrix_start_d;
  logic          fetch_rst_q, fetch_rst_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [15:0]   pixel_count_q, pixel_count_d;
  logic [15:0]   overrun_q, overrun_d;

  logic [GW-1:0] guard_inc;
  logic [IW-1:0] idle_inc;
  logic [15:0]   pix_inc;

  // Next-state and registered-output decode for the frame FSM.
  always_comb begin
    guard_inc = (guard_q == GUARD_MAX) ? guard_q : guard_q + GW'(1);
    idle_inc  = (bus.busy_in || bus.pixel_valid_in) ? '0 : idle_q + IW'(1);
    pix_inc   = bus.pixel_valid_in ? sat_inc16(pix_run_q) : pix_run_q;

    state_d        = state_q;
    guard_d        = guard_q;
    idle_d         = idle_q;
    pix_run_d      = pix_run_q;
    switch_d       = 1'b0;
    clear_d        = 1'b0;
    matrix_start_d = 1'b0;
    fetch_rst_d    = fetch_rst_q;
    frame_done_d   = 1'b0;
    frame_count_d  = frame_count_q;
    pixel_count_d  = pixel_count_q;
    // Any tick not consumed by a finished frame is a missed swap opportunity.
    overrun_d      = (tick && state_q != ST_DONE) ? sat_inc16(overrun_q) : overrun_q;

    case (state_q)
      ST_START: begin
        clear_d        = 1'b1;
        matrix_start_d = 1'b1;
        guard_d        = '0;
        state_d        = ST_WAIT_MATRIX;
      end
      ST_WAIT_MATRIX: begin
        guard_d = guard_inc;
        if (bus.matrix_valid_in) state_d = ST_WAIT_BUFFER;
      end
      ST_WAIT_BUFFER: begin
        guard_d = guard_inc;
        // Ready is ignored until the clear has had time to reach the framebuffer.
        if (guard_q == GUARD_MAX && bus.buffer_ready_in) begin
          state_d     = ST_RENDER;
          fetch_rst_d = 1'b0;
          pix_run_d   = '0;
        end
      end
      ST_RENDER: begin
        pix_run_d = pix_inc;
        if (bus.fetch_done_in) begin
          state_d = ST_DRAIN;
          idle_d  = '0;
        end
      end
      ST_DRAIN: begin
        pix_run_d = pix_inc;
        idle_d    = idle_inc;
        if (idle_inc == IDLE_DONE) begin
          state_d       = ST_DONE;
          fetch_rst_d   = 1'b1;
          frame_done_d  = 1'b1;
          pixel_count_d = pix_run_q;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      ST_DONE: begin
        if (tick) begin
          switch_d = 1'b1;
          state_d  = ST_START;
        end
      end
      default: state_d = ST_START;
    endcase
  end

  // All sequencer state and registered outputs, synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= ST_START;
      guard_q        <= '0;
      idle_q         <= '0;
      pix_run_q      <= '0;
      switch_q       <= 1'b0;
      clear_q        <= 1'b0;
      matrix_start_q <= 1'b0;
      fetch_rst_q    <= 1'b1;
      frame_done_q   <= 1'b0;
      frame_count_q  <= '0;
      pixel_count_q  <= '0;
      overrun_q      <= '0;
    end else begin
      state_q        <= state_d;
      guard_q        <= guard_d;
      idle_q         <= idle_d;
      pix_run_q      <= pix_run_d;
      switch_q       <= switch_d;
      clear_q        <= clear_d;
      matrix_start_q <= matrix_start_d;
      fetch_rst_q    <= fetch_rst_d;
      frame_done_q   <= frame_done_d;
      frame_count_q  <= frame_count_d;
      pixel_count_q  <= pixel_count_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.switch_out        = switch_q;
  assign bus.clear_out         = clear_q;
  assign bus.matrix_start_out  = matrix_start_q;
  assign bus.fetch_rst_out     = fetch_rst_q;
  assign bus.frame_done_out    = frame_done_q;
  assign bus.frame_count_out   = frame_count_q;
  assign bus.pixel_count_out   = pixel_count_q;
  assign bus.overrun_count_out = overrun_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: hand-computed scenario table,
// reset / mid-frame reset sequences, and randomized runs against an
// event-level reference model.
module tb_frame_sequencer;

  localparam int P    = 100;
  localparam int DC   = 4;
  localparam int G    = 4;
  localparam int NMAX = 700;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  frame_sequencer_if bus();

  frame_sequencer #(.FRAME_PERIOD(P), .DRAIN_CYCLES(DC), .CLEAR_GUARD(G)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle stimulus and recorded outputs; cycle 0 is the first cycle after reset release.
  bit          mv[NMAX], rdy[NMAX], fd[NMAX], bz[NMAX], pv[NMAX];
  bit          r_clr[NMAX], r_ms[NMAX], r_sw[NMAX], r_fdone[NMAX], r_frst[NMAX];
  logic [15:0] r_fcnt[NMAX], r_pcnt[NMAX], r_ocnt[NMAX];

  task automatic clear_stim();
    for (int i = 0; i < NMAX; i++) begin
      mv[i] = 0; rdy[i] = 0; fd[i] = 0; bz[i] = 0; pv[i] = 0;
    end
  endtask

  task automatic drive_idle();
    bus.matrix_valid_in = 1'b0;
    bus.buffer_ready_in = 1'b0;
    bus.fetch_done_in   = 1'b0;
    bus.busy_in         = 1'b0;
    bus.pixel_valid_in  = 1'b0;
  endtask

  // Reset, then play n cycles of stimulus; rst_in is raised during cycle rst_at.
  task automatic run(input int n, input int rst_at);
    rst_in = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk_in);
    #1;
    for (int k = 0; k < n; k++) begin
      rst_in              = (k == rst_at);
      bus.matrix_valid_in = mv[k];
      bus.buffer_ready_in = rdy[k];
      bus.fetch_done_in   = fd[k];
      bus.busy_in         = bz[k];
      bus.pixel_valid_in  = pv[k];
      @(negedge clk_in);
      r_clr[k]   = bus.clear_out;
      r_ms[k]    = bus.matrix_start_out;
      r_sw[k]    = bus.switch_out;
      r_fdone[k] = bus.frame_done_out;
      r_frst[k]  = bus.fetch_rst_out;
      r_fcnt[k]  = bus.frame_count_out;
      r_pcnt[k]  = bus.pixel_count_out;
      r_ocnt[k]  = bus.overrun_count_out;
      @(posedge clk_in);
      #1;
    end
    rst_in = 1'b0;
  endtask

  function automatic int first_one(input bit a[NMAX], input int from, input int n);
    for (int i = from; i < n; i++) if (a[i]) return i;
    return n;
  endfunction

  function automatic int count_ones(input bit a[NMAX], input int from, input int to);
    int c = 0;
    for (int i = from; i <= to; i++) if (a[i]) c++;
    return c;
  endfunction

  function automatic int first_low_frst(input int n);
    for (int i = 0; i < n; i++) if (!r_frst[i]) return i;
    return n;
  endfunction

  // Scenario table: single-frame stimulus shape plus hand-derived expectations.
  typedef struct {
    string name;
    int mv_at, rdy_from, rdy_to, pix_start, pix_n, fd_at, busy_to;
    int exp_fall, exp_done, exp_pix, exp_switch, exp_ovr;
  } vec_t;

  vec_t tbl[6];

  task automatic load_row(input vec_t v);
    clear_stim();
    mv[v.mv_at] = 1;
    for (int t = v.rdy_from; t <= v.rdy_to && t < NMAX; t++) rdy[t] = 1;
    for (int i = 0; i < v.pix_n; i++) pv[v.pix_start + i] = 1;
    for (int t = v.fd_at; t < NMAX; t++) fd[t] = 1;
    for (int t = v.fd_at + 1; t <= v.busy_to; t++) if (t % 3 == 0) bz[t] = 1;
  endtask

  // Reference model: derive frame event times from the stimulus using the
  // frame rules directly, then compare against recorded DUT events.
  task automatic random_trial(input int trial, input int n, input int fdiv);
    int e_clr[$], e_fall[$], e_done[$], e_pix[$], e_sw[$];
    int a_clr[$], a_fall[$], a_done[$], a_sw[$];
    int s, c, m, lo, r, rs, f, d, run_len, cnt, w, exp_ovr;
    string tag;

    clear_stim();
    for (int i = 0; i < n; i++) begin
      mv[i]  = ($urandom % 4) == 0;
      rdy[i] = ($urandom % 2) == 0;
      pv[i]  = ($urandom % 3) == 0;
      bz[i]  = ($urandom % 4) == 0;
      fd[i]  = ($urandom % fdiv) == 0;
    end
    run(n, -1);

    s = 0;
    while (1) begin
      c = s + 1;
      if (c >= n) break;
      e_clr.push_back(c);
      m = first_one(mv, c, n);
      if (m >= n) break;
      lo = (m + 1 > c + G) ? m + 1 : c + G;
      r = first_one(rdy, lo, n);
      rs = r + 1;
      if (rs >= n) break;
      e_fall.push_back(rs);
      f = first_one(fd, rs, n);
      if (f >= n) break;
      d = -1;
      run_len = 0;
      for (int t = f + 1; t < n; t++) begin
        run_len = (!bz[t] && !pv[t]) ? run_len + 1 : 0;
        if (run_len == DC) begin d = t; break; end
      end
      if (d < 0 || d + 1 >= n) break;
      cnt = count_ones(pv, rs, d);
      if (cnt > 65535) cnt = 65535;
      e_done.push_back(d + 1);
      e_pix.push_back(cnt);
      w = d + 1;
      while (w % P != P - 1) w++;
      if (w + 1 >= n) break;
      e_sw.push_back(w + 1);
      s = w + 1;
    end
    exp_ovr = (n - 1) / P - e_sw.size();

    for (int k = 0; k < n; k++) begin
      if (r_clr[k])   a_clr.push_back(k);
      if (r_fdone[k]) a_done.push_back(k);
      if (r_sw[k])    a_sw.push_back(k);
      if (!r_frst[k] && (k == 0 || r_frst[k-1])) a_fall.push_back(k);
    end

    tag = $sformatf("rand%0d", trial);
    check({tag, " clear_events"}, a_clr.size(), e_clr.size());
    for (int i = 0; i < e_clr.size() && i < a_clr.size(); i++)
      check({tag, " clear_cycle"}, a_clr[i], e_clr[i]);
    check({tag, " fall_events"}, a_fall.size(), e_fall.size());
    for (int i = 0; i < e_fall.size() && i < a_fall.size(); i++)
      check({tag, " fetch_rst_fall"}, a_fall[i], e_fall[i]);
    check({tag, " done_events"}, a_done.size(), e_done.size());
    for (int i = 0; i < e_done.size() && i < a_done.size(); i++) begin
      check({tag, " done_cycle"}, a_done[i], e_done[i]);
      check({tag, " pixel_count"}, int'(r_pcnt[e_done[i]]), e_pix[i]);
      check({tag, " frame_count"}, int'(r_fcnt[e_done[i]]), i + 1);
    end
    check({tag, " switch_events"}, a_sw.size(), e_sw.size());
    for (int i = 0; i < e_sw.size() && i < a_sw.size(); i++)
      check({tag, " switch_cycle"}, a_sw[i], e_sw[i]);
    check({tag, " overrun_final"}, int'(r_ocnt[n-1]), exp_ovr);
  endtask

  initial begin
    int n;

    //              name            mv rdyF rdyT      pS pN  fd  busy fall done pix  sw  ovr
    tbl[0] = '{"normal",         5, 10,  10,       11, 20, 40,  0,  11,  45, 20, 100, 0};
    tbl[1] = '{"drain_restart",  5, 10,  10,       11, 20, 40, 70,  11,  74, 20, 100, 0};
    tbl[2] = '{"overrun",        5, 10,  10,       11, 20, 120, 0,  11, 125, 20, 200, 1};
    tbl[3] = '{"guard",          1,  0,  NMAX - 1,  6,  3, 10,  0,   6,  15,  3, 100, 0};
    tbl[4] = '{"done_on_tick",   5, 10,  10,       11,  0, 95,  0,  11, 100,  0, 200, 1};
    tbl[5] = '{"done_before_tick", 5, 10, 10,      11,  0, 94,  0,  11,  99,  0, 100, 0};

    // Values held during reset.
    rst_in = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst switch_out",       int'(bus.switch_out), 0);
    check("rst clear_out",        int'(bus.clear_out), 0);
    check("rst matrix_start_out", int'(bus.matrix_start_out), 0);
    check("rst frame_done_out",   int'(bus.frame_done_out), 0);
    check("rst fetch_rst_out",    int'(bus.fetch_rst_out), 1);
    check("rst frame_count",      int'(bus.frame_count_out), 0);
    check("rst pixel_count",      int'(bus.pixel_count_out), 0);
    check("rst overrun_count",    int'(bus.overrun_count_out), 0);

    // Table-driven single-frame scenarios.
    foreach (tbl[i]) begin
      n = tbl[i].exp_switch + 3;
      load_row(tbl[i]);
      run(n, -1);
      check({tbl[i].name, " first_clear"},   first_one(r_clr, 0, n), 1);
      check({tbl[i].name, " first_mstart"},  first_one(r_ms, 0, n), 1);
      check({tbl[i].name, " clears_in_frame"}, count_ones(r_clr, 0, tbl[i].exp_switch), 1);
      check({tbl[i].name, " fetch_rst_fall"}, first_low_frst(n), tbl[i].exp_fall);
      check({tbl[i].name, " frame_done"},    first_one(r_fdone, 0, n), tbl[i].exp_done);
      check({tbl[i].name, " pixel_count"},   int'(r_pcnt[tbl[i].exp_done]), tbl[i].exp_pix);
      check({tbl[i].name, " frame_count"},   int'(r_fcnt[tbl[i].exp_done]), 1);
      check({tbl[i].name, " switch"},        first_one(r_sw, 0, n), tbl[i].exp_switch);
      check({tbl[i].name, " overrun"},       int'(r_ocnt[tbl[i].exp_switch]), tbl[i].exp_ovr);
      check({tbl[i].name, " next_clear"},    first_one(r_clr, 2, n), tbl[i].exp_switch + 1);
    end

    // Mid-frame reset while rendering, after one overrun has been counted.
    load_row(tbl[2]);
    run(115, 110);
    check("midrst pre fetch_rst",  int'(r_frst[109]), 0);
    check("midrst pre overrun",    int'(r_ocnt[109]), 1);
    check("midrst fetch_rst",      int'(r_frst[111]), 1);
    check("midrst overrun",        int'(r_ocnt[111]), 0);
    check("midrst frame_count",    int'(r_fcnt[111]), 0);
    check("midrst pixel_count",    int'(r_pcnt[111]), 0);
    check("midrst clear_low",      int'(r_clr[111]), 0);
    check("midrst clear_restart",  int'(r_clr[112]), 1);
    check("midrst mstart_restart", int'(r_ms[112]), 1);
    check("midrst no_switch",      count_ones(r_sw, 0, 114), 0);

    // Randomized multi-frame runs, with a spread of fetch-done rates to hit overruns.
    for (int t = 0; t < 4; t++) random_trial(t, 600, $urandom_range(8, 150));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
